stream_elastic_buffer: RTL and testbench

Parametrised valid/ready elastic buffer for the Ethernet datapath, generalising the two-entry skid stage to DEPTH entries. It carries a data word plus an end-of-frame marker, exposes occupancy and almost-full status for upstream flow control, and supports a synchronous flush for frame-abort recovery. It sits between MAC pipeline stages wherever more than one beat of slack is needed, for example ahead of CRC insertion or across bursty arbitration points.

---
 rtl/stream_elastic_buffer.sv | 136 +++++++++++++
 tb/tb_stream_elastic_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_elastic_buffer.sv
// Valid/ready elastic buffer: DEPTH-entry ring of {last, data} with optional output register,
// registered occupancy/almost-full status and synchronous flush.
module stream_elastic_buffer #(
   parameter int DATAW     = 8,
   parameter int DEPTH     = 4,
   parameter int OUT_REG   = 0,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic                               valid_in,
   input  logic [DATAW-1:0]                   data_in,
   input  logic                               last_in,
   output logic                               ready_in,
   output logic                               valid_out,
   output logic [DATAW-1:0]                   data_out,
   output logic                               last_out,
   input  logic                               ready_out,
   output logic [$clog2(DEPTH+OUT_REG+1)-1:0] count,
   output logic                               almost_full
);

   localparam int CAP = DEPTH + OUT_REG;
   localparam int CW  = $clog2(CAP + 1);
   localparam int PW  = $clog2(DEPTH);
   localparam int EW  = DATAW + 1;

   logic [EW-1:0] mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          af_r;
   logic          push_s;
   logic          pop_s;
   logic          st_wr_s;
   logic          st_rd_s;
   logic [EW-1:0] head_s;

   // Acceptance depends only on registered occupancy, never on ready_out.
   assign ready_in = (count_r != CW'(CAP)) && !flush;
   assign push_s   = valid_in && ready_in;
   assign pop_s    = valid_out && ready_out && !flush;
   assign head_s   = mem_r[rd_ptr_r];

   // Total occupancy next-state from the external handshakes.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic          out_valid_r;
         logic [EW-1:0] out_entry_r;
         logic          out_load_s;
         logic          st_empty_s;

         // The output register is occupied whenever storage holds anything, so
         // storage is empty exactly when count equals the output register's share.
         always_comb begin
            st_empty_s = (count_r == CW'(out_valid_r));
            out_load_s = !out_valid_r || pop_s;
            st_rd_s    = out_load_s && !st_empty_s;
            st_wr_s    = push_s && !(out_load_s && st_empty_s);
         end

         // Output valid flag: refilled from storage head, else direct from input.
         always_ff @(posedge clk) begin
            if (reset || flush) begin
               out_valid_r <= 1'b0;
            end else if (out_load_s) begin
               out_valid_r <= !st_empty_s || push_s;
            end
         end

         // Output payload register, no reset needed.
         always_ff @(posedge clk) begin
            if (out_load_s) begin
               if (!st_empty_s) begin
                  out_entry_r <= head_s;
               end else if (push_s) begin
                  out_entry_r <= {last_in, data_in};
               end
            end
         end

         assign valid_out            = out_valid_r;
         assign {last_out, data_out} = out_entry_r;
      end else begin : g_no_out_reg
         // Storage is the whole buffer: handshakes map straight onto the ring.
         always_comb begin
            st_wr_s = push_s;
            st_rd_s = pop_s;
         end

         assign valid_out            = (count_r != CW'(0));
         assign {last_out, data_out} = head_s;
      end
   endgenerate

   // Ring storage write; contents are don't-care while not valid.
   always_ff @(posedge clk) begin
      if (st_wr_s) begin
         mem_r[wr_ptr_r] <= {last_in, data_in};
      end
   end

   // Pointers, occupancy and almost-full; reset and flush clear identically.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
         af_r     <= 1'b0;
      end else begin
         if (st_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (st_rd_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_nxt_s;
         af_r    <= (count_nxt_s >= CW'(AF_THRESH));
      end
   end

   assign count       = count_r;
   assign almost_full = af_r;

endmodule

// File: tb/tb_stream_elastic_buffer.sv
// Directed bench for stream_elastic_buffer: instance a (DEPTH=4, OUT_REG=0) and instance b (DEPTH=4, OUT_REG=1).
module tb_stream_elastic_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_flush, a_valid_in, a_last_in, a_ready_in, a_valid_out, a_last_out, a_ready_out, a_af;
   logic [7:0] a_data_in, a_data_out;
   logic [2:0] a_count;
   logic       b_flush, b_valid_in, b_last_in, b_ready_in, b_valid_out, b_last_out, b_ready_out, b_af;
   logic [7:0] b_data_in, b_data_out;
   logic [2:0] b_count;

   int checks   = 0;
   int failures = 0;

   stream_elastic_buffer #(.DATAW(8), .DEPTH(4), .OUT_REG(0)) u_dut_a (
      .clk(clk), .reset(reset), .flush(a_flush), .valid_in(a_valid_in), .data_in(a_data_in),
      .last_in(a_last_in), .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out),
      .last_out(a_last_out), .ready_out(a_ready_out), .count(a_count), .almost_full(a_af));

   stream_elastic_buffer #(.DATAW(8), .DEPTH(4), .OUT_REG(1)) u_dut_b (
      .clk(clk), .reset(reset), .flush(b_flush), .valid_in(b_valid_in), .data_in(b_data_in),
      .last_in(b_last_in), .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out),
      .last_out(b_last_out), .ready_out(b_ready_out), .count(b_count), .almost_full(b_af));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      #1;
      checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
      checks++; if (a_valid_out !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid_out); end
      checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL reset_a_af got=%b exp=0", a_af); end
      checks++; if (a_ready_in !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", a_ready_in); end
      checks++; if (b_count !== 3'd0) begin failures++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
      checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid_out); end
      checks++; if (b_af !== 1'b0) begin failures++; $display("FAIL reset_b_af got=%b exp=0", b_af); end
      checks++; if (b_ready_in !== 1'b1) begin failures++; $display("FAIL reset_b_ready got=%b exp=1", b_ready_in); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp;
      a_ready_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_valid_in = 1'b1;
         a_data_in  = 8'(8'h11 + i);
         a_last_in  = (i == 3);
         #1;
         checks++; if (a_ready_in !== 1'b1) begin failures++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, a_ready_in); end
         cyc();
         checks++; if (a_count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, a_count, i + 1); end
         checks++; if (a_af !== (i + 1 >= 3)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, a_af, (i + 1 >= 3)); end
      end
      a_valid_in = 1'b0;
      #1;
      checks++; if (a_ready_in !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", a_ready_in); end
      a_ready_out = 1'b1;
      for (int j = 0; j < 4; j++) begin
         exp = 8'(8'h11 + j);
         #1;
         checks++; if (a_valid_out !== 1'b1) begin failures++; $display("FAIL drain_valid j=%0d got=%b exp=1", j, a_valid_out); end
         checks++; if (a_data_out !== exp) begin failures++; $display("FAIL drain_data j=%0d got=%h exp=%h", j, a_data_out, exp); end
         checks++; if (a_last_out !== (j == 3)) begin failures++; $display("FAIL drain_last j=%0d got=%b exp=%b", j, a_last_out, (j == 3)); end
         cyc();
         checks++; if (a_count !== 3'(3 - j)) begin failures++; $display("FAIL drain_count j=%0d got=%0d exp=%0d", j, a_count, 3 - j); end
      end
      checks++; if (a_valid_out !== 1'b0) begin failures++; $display("FAIL drained_valid got=%b exp=0", a_valid_out); end
      checks++; if (a_ready_in !== 1'b1) begin failures++; $display("FAIL drained_ready got=%b exp=1", a_ready_in); end
      checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL drained_af got=%b exp=0", a_af); end
      a_ready_out = 1'b0;
      a_last_in   = 1'b0;
   endtask

   task automatic test_simultaneous();
      a_ready_out = 1'b0;
      a_valid_in  = 1'b1;
      a_data_in   = 8'h21; cyc();
      a_data_in   = 8'h22; cyc();
      a_ready_out = 1'b1;
      for (int k = 0; k < 2; k++) begin
         a_data_in = 8'(8'h23 + k);
         #1;
         checks++; if (a_data_out !== 8'(8'h21 + k)) begin failures++; $display("FAIL simul_data k=%0d got=%h exp=%h", k, a_data_out, 8'(8'h21 + k)); end
         cyc();
         checks++; if (a_count !== 3'd2) begin failures++; $display("FAIL simul_count k=%0d got=%0d exp=2", k, a_count); end
      end
      a_valid_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (a_data_out !== 8'(8'h23 + k)) begin failures++; $display("FAIL simul_tail k=%0d got=%h exp=%h", k, a_data_out, 8'(8'h23 + k)); end
         cyc();
      end
      checks++; if (a_valid_out !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", a_valid_out); end
      a_ready_out = 1'b0;
   endtask

   task automatic test_wrap();
      int n_in  = 0;
      int n_out = 0;
      int c     = 0;
      logic push, pop;
      while (n_out < 10 && c < 200) begin
         a_valid_in  = (n_in < 10);
         a_data_in   = 8'(8'h30 + n_in);
         a_ready_out = c[0];
         #1;
         push = a_valid_in && a_ready_in;
         pop  = a_valid_out && a_ready_out;
         if (pop) begin
            checks++; if (a_data_out !== 8'(8'h30 + n_out)) begin failures++; $display("FAIL wrap_data n=%0d got=%h exp=%h", n_out, a_data_out, 8'(8'h30 + n_out)); end
            n_out++;
         end
         cyc();
         if (push) n_in++;
         checks++; if (a_count !== 3'(n_in - n_out)) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", a_count, n_in - n_out); end
         c++;
      end
      checks++; if (n_out != 10) begin failures++; $display("FAIL wrap_timeout got=%0d exp=10", n_out); end
      a_valid_in  = 1'b0;
      a_ready_out = 1'b0;
   endtask

   task automatic test_flush();
      a_ready_out = 1'b0;
      a_valid_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_data_in = 8'(8'h41 + i);
         cyc();
      end
      checks++; if (a_count !== 3'd3 || a_af !== 1'b1) begin failures++; $display("FAIL preflush got=%0d/%b exp=3/1", a_count, a_af); end
      a_flush     = 1'b1;
      a_data_in   = 8'h99;
      a_ready_out = 1'b1;
      #1;
      checks++; if (a_ready_in !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", a_ready_in); end
      cyc();
      a_flush     = 1'b0;
      a_valid_in  = 1'b0;
      a_ready_out = 1'b0;
      #1;
      checks++; if (a_valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", a_valid_out); end
      checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", a_count); end
      checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL flush_af got=%b exp=0", a_af); end
      checks++; if (a_ready_in !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", a_ready_in); end
      a_valid_in = 1'b1;
      a_data_in  = 8'hA5;
      cyc();
      a_valid_in = 1'b0;
      #1;
      checks++; if (a_valid_out !== 1'b1 || a_data_out !== 8'hA5) begin failures++; $display("FAIL post_flush_data got=%b/%h exp=1/a5", a_valid_out, a_data_out); end
      checks++; if (a_count !== 3'd1) begin failures++; $display("FAIL post_flush_count got=%0d exp=1", a_count); end
      a_ready_out = 1'b1;
      cyc();
      checks++; if (a_valid_out !== 1'b0 || a_count !== 3'd0) begin failures++; $display("FAIL post_flush_alone got=%b/%0d exp=0/0", a_valid_out, a_count); end
      a_ready_out = 1'b0;
   endtask

   task automatic test_streaming();
      b_ready_out = 1'b1;
      for (int k = 0; k <= 64; k++) begin
         b_valid_in = (k < 64);
         b_data_in  = 8'(k);
         b_last_in  = (k == 63);
         #1;
         if (k > 0) begin
            checks++; if (b_valid_out !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, b_valid_out); end
            checks++; if (b_data_out !== 8'(k - 1)) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, b_data_out, 8'(k - 1)); end
            checks++; if (b_last_out !== (k == 64)) begin failures++; $display("FAIL stream_last k=%0d got=%b exp=%b", k, b_last_out, (k == 64)); end
            checks++; if (b_count !== 3'd1) begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, b_count); end
         end
         checks++; if (b_ready_in !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, b_ready_in); end
         cyc();
      end
      checks++; if (b_valid_out !== 1'b0 || b_count !== 3'd0) begin failures++; $display("FAIL stream_end got=%b/%0d exp=0/0", b_valid_out, b_count); end
      b_valid_in  = 1'b0;
      b_last_in   = 1'b0;
      b_ready_out = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      b_ready_out = 1'b0;
      b_valid_in  = 1'b1;
      b_data_in   = 8'h51; cyc();
      b_data_in   = 8'h52; cyc();
      b_valid_in  = 1'b0;
      #1;
      checks++; if (b_count !== 3'd2) begin failures++; $display("FAIL midrst_pre got=%0d exp=2", b_count); end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", b_valid_out); end
      checks++; if (b_count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", b_count); end
      checks++; if (b_ready_in !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", b_ready_in); end
      b_ready_out = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         b_valid_in = (k < 3);
         b_data_in  = 8'(8'h61 + k);
         b_last_in  = (k == 2);
         #1;
         if (k > 0) begin
            checks++; if (b_valid_out !== 1'b1 || b_data_out !== 8'(8'h60 + k)) begin failures++; $display("FAIL midrst_frame k=%0d got=%b/%h exp=1/%h", k, b_valid_out, b_data_out, 8'(8'h60 + k)); end
            checks++; if (b_last_out !== (k == 3)) begin failures++; $display("FAIL midrst_last k=%0d got=%b exp=%b", k, b_last_out, (k == 3)); end
         end
         cyc();
      end
      checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL midrst_end got=%b exp=0", b_valid_out); end
      b_valid_in  = 1'b0;
      b_last_in   = 1'b0;
      b_ready_out = 1'b0;
   endtask

   task automatic test_random();
      logic [8:0] q[$];
      logic [8:0] exp;
      logic [8:0] prev_out;
      logic       prev_stall = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         b_valid_in  = 1'($urandom_range(0, 1));
         b_data_in   = 8'($urandom);
         b_last_in   = 1'($urandom);
         b_ready_out = 1'($urandom_range(0, 1));
         #1;
         if (prev_stall) begin
            checks++; if (b_valid_out !== 1'b1 || {b_last_out, b_data_out} !== prev_out) begin failures++; $display("FAIL rand_stable c=%0d got=%b/%h exp=1/%h", c, b_valid_out, {b_last_out, b_data_out}, prev_out); end
         end
         if (b_valid_out && b_ready_out) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rand_underflow c=%0d got=valid exp=empty", c);
            end else begin
               exp = q.pop_front();
               if ({b_last_out, b_data_out} !== exp) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, {b_last_out, b_data_out}, exp); end
            end
         end
         if (b_valid_in && b_ready_in) q.push_back({b_last_in, b_data_in});
         prev_stall = b_valid_out && !b_ready_out;
         prev_out   = {b_last_out, b_data_out};
         cyc();
         checks++; if (b_count !== 3'(q.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, b_count, q.size()); end
      end
      b_valid_in  = 1'b0;
      b_ready_out = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      a_flush = 1'b0; a_valid_in = 1'b0; a_data_in = 8'h00; a_last_in = 1'b0; a_ready_out = 1'b0;
      b_flush = 1'b0; b_valid_in = 1'b0; b_data_in = 8'h00; b_last_in = 1'b0; b_ready_out = 1'b0;
      test_reset();
      test_fill_drain();
      test_simultaneous();
      test_wrap();
      test_flush();
      test_streaming();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
